cache_cmd_dispatcher: RTL and testbench

Trace-command scheduler between the trace reader and the two L1 caches (instruction and data).
- Buffers incoming trace records in a small FIFO and decodes each trace code into a cache command.
- Issues each command to the IL1, the DL1, or both in sequence, using the caches' write/processing handshake.
- Recovers from a cache that never finishes by timing out, and counts errors.

---
 rtl/cache_cmd_dispatcher_if.sv | 39 +++
 rtl/cache_cmd_dispatcher.sv | 230 +++++++++++++++++++++++
 tb/tb_cache_cmd_dispatcher.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_cmd_dispatcher_if.sv
// Trace-in and L1 cache handshake bundle for the command dispatcher.
// Ports: in_valid/in_ready/in_code/in_addr from the trace reader;
//        ic_*/dc_* write strobe, command, address and processing flag.
interface cache_cmd_dispatcher_if #(
    parameter int ADDR_W = 60
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_code;
    logic [ADDR_W-1:0] in_addr;

    logic              ic_write;
    logic [2:0]        ic_command;
    logic [ADDR_W-1:0] ic_address;
    logic              ic_processing;

    logic              dc_write;
    logic [2:0]        dc_command;
    logic [ADDR_W-1:0] dc_address;
    logic              dc_processing;

    // Trace reader plus both caches
    modport master (
        output in_valid, in_code, in_addr,
        output ic_processing, dc_processing,
        input  in_ready,
        input  ic_write, ic_command, ic_address,
        input  dc_write, dc_command, dc_address
    );

    // Dispatcher
    modport slave (
        input  in_valid, in_code, in_addr,
        input  ic_processing, dc_processing,
        output in_ready,
        output ic_write, ic_command, ic_address,
        output dc_write, dc_command, dc_address
    );
endinterface

// File: rtl/cache_cmd_dispatcher.sv
// Trace-command scheduler: FIFOs trace records, decodes them and issues
// one command at a time to the IL1 and/or DL1 with timeout recovery.
// Ports: clk, rst (sync, active-high), bus (slave side of the trace and
//        cache handshakes), print_req, busy, err_count, dispatched.
module cache_cmd_dispatcher #(
    parameter int ADDR_W     = 60,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_cmd_dispatcher_if.slave bus,
    output logic                  print_req,
    output logic                  busy,
    output logic [15:0]           err_count,
    output logic [31:0]           dispatched
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] CMD_READ  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_INV   = 3'd2;
    localparam logic [2:0] CMD_CLEAR = 3'd3;
    localparam logic [2:0] CMD_L2REQ = 3'd4;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT
    } state_t;

    state_t state, state_n;

    logic [3:0]        f_code [FIFO_DEPTH];
    logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  f_cnt;
    logic              full, empty, push, pop;
    logic [3:0]        head_code;

    logic              tgt_ic, dual;
    logic [2:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [TMO_W-1:0]  tmo;
    logic [2:0]        ic_cmd_h, dc_cmd_h;
    logic [ADDR_W-1:0] ic_addr_h, dc_addr_h;

    logic              dec_legal, dec_print, dec_ic, dec_dual;
    logic [2:0]        dec_cmd;
    logic              ic_wr, dc_wr, err_inc, disp_inc;
    logic              latch, retarget, tmo_clr, tgt_busy, tmo_hit;

    assign full      = (f_cnt == CNT_W'(FIFO_DEPTH));
    assign empty     = (f_cnt == '0);
    assign push      = bus.in_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign head_code = f_code[rd_ptr];

    assign bus.in_ready   = !full;
    assign busy           = !empty || (state != IDLE);
    // Command/address track the latched command only while strobing,
    // otherwise they show the last value actually issued.
    assign bus.ic_write   = ic_wr;
    assign bus.ic_command = ic_wr ? cmd_q : ic_cmd_h;
    assign bus.ic_address = ic_wr ? addr_q : ic_addr_h;
    assign bus.dc_write   = dc_wr;
    assign bus.dc_command = dc_wr ? cmd_q : dc_cmd_h;
    assign bus.dc_address = dc_wr ? addr_q : dc_addr_h;

    always_comb begin
        dec_legal = 1'b1;
        dec_print = 1'b0;
        dec_ic    = 1'b0;
        dec_dual  = 1'b0;
        dec_cmd   = CMD_READ;
        case (head_code)
            4'd0: dec_cmd = CMD_READ;
            4'd1: dec_cmd = CMD_WRITE;
            4'd2: dec_ic  = 1'b1;
            4'd3: begin
                dec_ic   = 1'b1;
                dec_dual = 1'b1;
                dec_cmd  = CMD_INV;
            end
            4'd4: dec_cmd = CMD_L2REQ;
            4'd8: begin
                dec_ic   = 1'b1;
                dec_dual = 1'b1;
                dec_cmd  = CMD_CLEAR;
            end
            4'd9: begin
                dec_legal = 1'b0;
                dec_print = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_n   = state;
        ic_wr     = 1'b0;
        dc_wr     = 1'b0;
        print_req = 1'b0;
        err_inc   = 1'b0;
        disp_inc  = 1'b0;
        latch     = 1'b0;
        retarget  = 1'b0;
        tmo_clr   = 1'b0;
        tgt_busy  = tgt_ic ? bus.ic_processing : bus.dc_processing;
        tmo_hit   = (tmo == TMO_W'(TIMEOUT - 1));
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    if (dec_print) begin
                        print_req = 1'b1;
                    end else if (!dec_legal) begin
                        err_inc = 1'b1;
                    end else begin
                        latch   = 1'b1;
                        tmo_clr = 1'b1;
                        state_n = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // Timeout wins here so an abandoned command is never strobed.
                if (tmo_hit) begin
                    err_inc = 1'b1;
                    state_n = NEXT;
                end else if (!tgt_busy) begin
                    ic_wr   = tgt_ic;
                    dc_wr   = !tgt_ic;
                    state_n = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tgt_busy) begin
                    state_n = WAIT_DONE;
                end else if (tmo_hit) begin
                    err_inc = 1'b1;
                    state_n = NEXT;
                end
            end
            WAIT_DONE: begin
                if (!tgt_busy) begin
                    disp_inc = 1'b1;
                    state_n  = NEXT;
                end else if (tmo_hit) begin
                    err_inc = 1'b1;
                    state_n = NEXT;
                end
            end
            NEXT: begin
                if (dual && tgt_ic) begin
                    retarget = 1'b1;
                    tmo_clr  = 1'b1;
                    state_n  = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (rst) begin
            ic_wr     = 1'b0;
            dc_wr     = 1'b0;
            print_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_code[wr_ptr] <= bus.in_code;
            f_addr[wr_ptr] <= bus.in_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            f_cnt      <= '0;
            tgt_ic     <= 1'b0;
            dual       <= 1'b0;
            cmd_q      <= '0;
            addr_q     <= '0;
            tmo        <= '0;
            ic_cmd_h   <= '0;
            ic_addr_h  <= '0;
            dc_cmd_h   <= '0;
            dc_addr_h  <= '0;
            err_count  <= '0;
            dispatched <= '0;
        end else begin
            state <= state_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   f_cnt <= f_cnt + 1'b1;
                2'b01:   f_cnt <= f_cnt - 1'b1;
                default: f_cnt <= f_cnt;
            endcase
            if (latch) begin
                tgt_ic <= dec_ic;
                dual   <= dec_dual;
                cmd_q  <= dec_cmd;
                addr_q <= f_addr[rd_ptr];
            end
            if (retarget) tgt_ic <= 1'b0;
            // Saturates at TIMEOUT-1 so a late ack cannot skip the limit.
            if (tmo_clr) begin
                tmo <= '0;
            end else if ((state == ISSUE || state == WAIT_ACK ||
                          state == WAIT_DONE) && !tmo_hit) begin
                tmo <= tmo + 1'b1;
            end
            if (ic_wr) begin
                ic_cmd_h  <= cmd_q;
                ic_addr_h <= addr_q;
            end
            if (dc_wr) begin
                dc_cmd_h  <= cmd_q;
                dc_addr_h <= addr_q;
            end
            if (err_inc && err_count != 16'hFFFF) err_count <= err_count + 1'b1;
            if (disp_inc) dispatched <= dispatched + 1'b1;
        end
    end
endmodule

// File: tb/tb_cache_cmd_dispatcher.sv
// Self-checking bench for cache_cmd_dispatcher: directed plan steps plus
// random traces scored against a trace-level expected-event queue.
module tb_cache_cmd_dispatcher;
    localparam int ADDR_W = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic        print_req, busy;
    logic [15:0] err_count;
    logic [31:0] dispatched;

    always #5 clk = ~clk;

    cache_cmd_dispatcher_if #(.ADDR_W(ADDR_W)) bus ();

    cache_cmd_dispatcher #(
        .ADDR_W(ADDR_W), .FIFO_DEPTH(4), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .print_req(print_req), .busy(busy),
        .err_count(err_count), .dispatched(dispatched)
    );

    // Cache models: busy for a latency after each strobe, or held busy.
    int ic_cnt, dc_cnt;
    int ic_lat = 2, dc_lat = 2;
    bit ic_hold, dc_hold, rnd_lat;

    function automatic int pick(input int base);
        return rnd_lat ? int'($urandom_range(1, 4)) : base;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            ic_cnt <= 0;
            dc_cnt <= 0;
        end else begin
            if (bus.ic_write) ic_cnt <= pick(ic_lat);
            else if (ic_cnt > 0) ic_cnt <= ic_cnt - 1;
            if (bus.dc_write) dc_cnt <= pick(dc_lat);
            else if (dc_cnt > 0) dc_cnt <= dc_cnt - 1;
        end
    end

    assign bus.ic_processing = ic_hold || (ic_cnt > 0);
    assign bus.dc_processing = dc_hold || (dc_cnt > 0);

    // Reference model: per trace record, the events the caches must see.
    typedef struct {
        int                kind;  // 0 IL1, 1 DL1, 2 print
        logic [2:0]        cmd;
        logic [ADDR_W-1:0] addr;
    } ev_t;

    ev_t exp_q[$];
    int  exp_err, exp_disp;
    int  ncmp, nfail;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void exp_cmd(input int k, input logic [2:0] c,
                                    input logic [ADDR_W-1:0] a,
                                    input bit dead);
        ev_t e;
        if (dead) begin
            exp_err++;
        end else begin
            e.kind = k;
            e.cmd  = c;
            e.addr = a;
            exp_q.push_back(e);
            exp_disp++;
        end
    endfunction

    function automatic void model(input logic [3:0] code,
                                  input logic [ADDR_W-1:0] a,
                                  input bit ic_dead);
        ev_t e;
        case (code)
            4'd0: exp_cmd(1, 3'd0, a, 1'b0);
            4'd1: exp_cmd(1, 3'd1, a, 1'b0);
            4'd2: exp_cmd(0, 3'd0, a, ic_dead);
            4'd3: begin
                exp_cmd(0, 3'd2, a, ic_dead);
                exp_cmd(1, 3'd2, a, 1'b0);
            end
            4'd4: exp_cmd(1, 3'd4, a, 1'b0);
            4'd8: begin
                exp_cmd(0, 3'd3, a, ic_dead);
                exp_cmd(1, 3'd3, a, 1'b0);
            end
            4'd9: begin
                e.kind = 2;
                e.cmd  = 3'd0;
                e.addr = '0;
                exp_q.push_back(e);
            end
            default: exp_err++;
        endcase
    endfunction

    task automatic push(input logic [3:0] code, input logic [ADDR_W-1:0] a,
                        input bit ic_dead);
        int n;
        model(code, a, ic_dead);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        bus.in_addr  = a;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_in_budget", {63'd0, busy}, 64'd0);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_err"}, err_count, exp_err);
        chk({tag, "_disp"}, dispatched, exp_disp);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[ADDR_W-1:0];
    endfunction

    // Event monitor: every strobe/print must match the next expected event.
    int  mon_kind;
    ev_t mon_ev;
    always @(negedge clk) begin
        if (!rst && (bus.ic_write || bus.dc_write || print_req)) begin
            chk("one_event_per_cycle",
                {61'd0, bus.ic_write, bus.dc_write, print_req} inside
                {64'd4, 64'd2, 64'd1}, 64'd1);
            mon_kind = print_req ? 2 : (bus.ic_write ? 0 : 1);
            if (exp_q.size() == 0) begin
                ncmp++;
                nfail++;
                $error("FAIL unexpected_event: got kind %0d expected none",
                       mon_kind);
            end else begin
                mon_ev = exp_q.pop_front();
                chk("event_kind", mon_kind, mon_ev.kind);
                if (mon_kind == 0) begin
                    chk("ic_command", bus.ic_command, mon_ev.cmd);
                    chk("ic_address", bus.ic_address, mon_ev.addr);
                end else if (mon_kind == 1) begin
                    chk("dc_command", bus.dc_command, mon_ev.cmd);
                    chk("dc_address", bus.dc_address, mon_ev.addr);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] a;
        int n;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_code  = '0;
        bus.in_addr  = '0;
        ic_hold      = 1'b0;
        dc_hold      = 1'b0;
        rnd_lat      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ic_write", bus.ic_write, 0);
        chk("rst_dc_write", bus.dc_write, 0);
        chk("rst_print", print_req, 0);
        chk("rst_err", err_count, 0);
        chk("rst_disp", dispatched, 0);

        // IL1 read
        push(4'd2, 60'h0000_0000_ABC_DE40, 1'b0);
        wait_idle(50);
        chk_counts("il1_read");
        chk("ic_addr_hold", bus.ic_address, 60'h0000_0000_ABC_DE40);
        chk("ic_cmd_hold", bus.ic_command, 0);

        // Dual-target clear
        push(4'd8, rnd_addr(), 1'b0);
        wait_idle(50);
        chk_counts("clear");

        // Invalidate with the IL1 stuck busy
        ic_hold = 1'b1;
        a = rnd_addr();
        push(4'd3, a, 1'b1);
        n = 0;
        while (err_count == exp_err - 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 66);
        wait_idle(100);
        ic_hold = 1'b0;
        chk_counts("timeout");
        chk("dc_cmd_after_timeout", bus.dc_command, 2);
        chk("dc_addr_after_timeout", bus.dc_address, a);

        // Illegal, print, DL1 read back-to-back
        push(4'd5, rnd_addr(), 1'b0);
        push(4'd9, rnd_addr(), 1'b0);
        push(4'd0, rnd_addr(), 1'b0);
        wait_idle(50);
        chk_counts("mixed");

        // FIFO full with one command stuck in ISSUE
        dc_hold = 1'b1;
        for (int i = 0; i < 5; i++) push(4'd0, rnd_addr(), 1'b0);
        @(negedge clk);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_busy", busy, 1);
        fork
            push(4'd1, rnd_addr(), 1'b0);
            begin
                repeat (6) @(negedge clk);
                chk("still_full", bus.in_ready, 0);
                dc_hold = 1'b0;
            end
        join
        wait_idle(300);
        chk_counts("fifo_full");

        // Random traces, random cache latency
        rnd_lat = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(4'($urandom_range(0, 15)), rnd_addr(), 1'b0);
        end
        wait_idle(3000);
        chk_counts("random");
        rnd_lat = 1'b0;

        // Reset while the DL1 is mid-operation
        dc_lat = 20;
        push(4'd1, rnd_addr(), 1'b0);
        push(4'd0, rnd_addr(), 1'b0);
        push(4'd2, rnd_addr(), 1'b0);
        n = 0;
        while (!bus.dc_write && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("saw_dc_strobe", bus.dc_write, 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        chk("rst_cycle_ic_write", bus.ic_write, 0);
        chk("rst_cycle_dc_write", bus.dc_write, 0);
        exp_q.delete();
        exp_err  = 0;
        exp_disp = 0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_err", err_count, 0);
        chk("midrst_disp", dispatched, 0);
        rst    = 1'b0;
        dc_lat = 2;
        push(4'd4, rnd_addr(), 1'b0);
        wait_idle(50);
        chk_counts("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
